if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode; owns the program counter and the IF/ID pipeline register.
- Loads the start PC supplied to the processor top (e.g. 600) on reset, then fetches sequentially.
- Applies redirects from ID (jump) and EX (branch), and honours hazard-unit stalls.
- Instruction memory is external, with combinational read.

---
 rtl/if_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
// Branch (EX) outranks jump (ID), which outranks a hazard stall; otherwise fetch sequentially.
module if_stage #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] start_pc,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] program_counter,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        pc_oob,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ACT_FETCH    = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIR_ID = 2'd2,
    ACT_REDIR_EX = 2'd3
  } action_e;

  action_e     action_s;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign pc_plus4_s = pc_q + 32'd4;

  // Select the single action for this cycle; the branch is the older instruction.
  always_comb begin
    action_s = ACT_FETCH;
    if (branch_taken) begin
      action_s = ACT_REDIR_EX;
    end else if (jump_taken) begin
      action_s = ACT_REDIR_ID;
    end else if (stall) begin
      action_s = ACT_HOLD;
    end else begin
      action_s = ACT_FETCH;
    end
  end

  // Next-state values for PC, IF/ID and the fetch counter.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (action_s)
      ACT_REDIR_EX: begin
        pc_d    = word_align(branch_target);
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      ACT_REDIR_ID: begin
        pc_d    = word_align(jump_target);
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      ACT_HOLD: begin
        pc_d    = pc_q;
        instr_d = instr_q;
      end
      ACT_FETCH: begin
        pc_d    = pc_plus4_s;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4_s;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
      default: begin
        pc_d    = pc_q;
        instr_d = instr_q;
      end
    endcase
  end

  // State registers; reset discards any in-flight IF/ID contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= word_align(start_pc);
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign program_counter = pc_q;
  assign imem_addr       = pc_q;
  assign ifid_instr      = instr_q;
  assign ifid_pc4        = pc4_q;
  assign ifid_valid      = valid_q;
  assign fetch_count     = count_q;
  assign pc_oob          = ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));

endmodule
